// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one combinational ALU between two requesters.
// Rev 1.0 - initial release.
`default_nettype none

module alu_arbiter #(
  parameter int DATA_W = 32,
  parameter int FUNC_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0,
  input  logic              req1,
  input  logic [1:0]        op0,
  input  logic [1:0]        op1,
  input  logic [FUNC_W-1:0] func0,
  input  logic [FUNC_W-1:0] func1,
  input  logic [DATA_W-1:0] a0,
  input  logic [DATA_W-1:0] a1,
  input  logic [DATA_W-1:0] b0,
  input  logic [DATA_W-1:0] b1,
  output logic              ack0,
  output logic              ack1,
  output logic              done0,
  output logic              done1,
  output logic [1:0]        aluOp,
  output logic [FUNC_W-1:0] aluFunc,
  output logic [DATA_W-1:0] aluIn1,
  output logic [DATA_W-1:0] aluIn2,
  input  logic [DATA_W-1:0] aluOut,
  input  logic              aluZero,
  output logic [DATA_W-1:0] result,
  output logic              zeroOut,
  output logic              errOut,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   gnt;
  logic   last_grant;
  logic   grant_valid;
  logic   grant_sel;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // On a tie the requester that did not win last time gets the ALU.
  always_comb begin
    state_nxt   = state;
    grant_valid = 1'b0;
    grant_sel   = 1'b0;
    case (state)
      IDLE: begin
        if (req0 || req1) begin
          grant_valid = 1'b1;
          grant_sel   = (req0 && req1) ? ~last_grant : req1;
          state_nxt   = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gnt        <= 1'b0;
      last_grant <= 1'b1;
      aluOp      <= '0;
      aluFunc    <= '0;
      aluIn1     <= '0;
      aluIn2     <= '0;
      result     <= '0;
      zeroOut    <= 1'b0;
      errOut     <= 1'b0;
    end else begin
      if (grant_valid) begin
        gnt        <= grant_sel;
        last_grant <= grant_sel;
        aluOp      <= grant_sel ? op1   : op0;
        aluFunc    <= grant_sel ? func1 : func0;
        aluIn1     <= grant_sel ? a1    : a0;
        aluIn2     <= grant_sel ? b1    : b0;
      end
      if (state == EXEC) begin
        // ALUOp 2'b11 has no defined ALU function, so its output is discarded.
        if (aluOp == 2'b11) begin
          result  <= '0;
          zeroOut <= 1'b1;
          errOut  <= 1'b1;
        end else begin
          result  <= aluOut;
          zeroOut <= aluZero;
          errOut  <= 1'b0;
        end
      end
    end
  end

  assign ack0  = (state == EXEC) && !gnt;
  assign ack1  = (state == EXEC) &&  gnt;
  assign done0 = (state == RESP) && !gnt;
  assign done1 = (state == RESP) &&  gnt;
  assign busy  = (state != IDLE);

endmodule

`default_nettype wire

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares the single combinational ALU between two requesters, e.g. the execute stage and an address/branch-compare unit.
- Arbitrates round-robin and latches the winner's operands into registers that drive the ALU inputs.
- Captures ALUOut/zeroFlag into a result register and returns it with a one-cycle done pulse to the granted requester.

Parameters:
- DATA_W, 32, operand/result width (matches ALU in1/in2/ALUOut).
- FUNC_W, 6, func field width.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req0, req1  input  1  request from requester 0/1; held high with operands stable until ack.
- op0, op1  input  2  ALUOp from requester 0/1.
- func0, func1  input  FUNC_W  func field from requester 0/1.
- a0, a1  input  DATA_W  in1 operand from requester 0/1.
- b0, b1  input  DATA_W  in2 operand (shamt for shifts) from requester 0/1.
- ack0, ack1  output  1  one-cycle pulse: request accepted, operands latched.
- done0, done1  output  1  one-cycle pulse: result/zeroOut valid for this requester.
- aluOp  output  2  to ALU ALUOp (registered).
- aluFunc  output  FUNC_W  to ALU func (registered).
- aluIn1, aluIn2  output  DATA_W  to ALU in1/in2 (registered).
- aluOut  input  DATA_W  from ALU ALUOut.
- aluZero  input  1  from ALU zeroFlag.
- result  output  DATA_W  captured ALU result; held until next capture.
- zeroOut  output  1  captured zero flag; held with result.
- errOut  output  1  the current result came from an illegal op; held with result.
- busy  output  1  high whenever state != IDLE.

Behaviour:
- Reset (async, any time):
  - state=IDLE, lastGrant=1, so req0 wins the first tie.
  - ack0/1, done0/1, busy, errOut, zeroOut = 0.
  - result, aluOp, aluFunc, aluIn1, aluIn2 = 0.
  - An in-flight operation is dropped; no done is issued for it.
- FSM states: IDLE, EXEC, RESP. Fixed sequence IDLE->EXEC->RESP->IDLE.
- IDLE:
  - No request sampled at the rising edge: stay in IDLE.
  - Exactly one reqN sampled high: grant N.
  - Both sampled high: grant the requester != lastGrant.
  - On grant: latch opN/funcN/aN/bN into aluOp/aluFunc/aluIn1/aluIn2, set gnt=N, lastGrant=N, go to EXEC.
- EXEC:
  - ackN=1 for this cycle only; ALU inputs stable from the registers.
  - Requester must deassert req by this cycle's closing edge or it is treated as a new request.
  - At the closing edge: result<=aluOut, zeroOut<=aluZero, errOut<=0; go to RESP.
- RESP:
  - doneN=1 for this cycle only, for N=gnt; result/zeroOut/errOut valid.
  - Go to IDLE; result/zeroOut/errOut hold until the next EXEC capture.
- Latency and throughput:
  - Request sampled at edge E0 -> ack during cycle E0-E1 -> done and result during cycle E1-E2.
  - Peak throughput is one operation per 3 cycles.
  - Requests arriving while busy are not sampled; they wait, no loss.
- Illegal op (latched aluOp==2'b11):
  - The ALU output is not used.
  - At the EXEC closing edge: result<=0, zeroOut<=1, errOut<=1.
  - done is pulsed normally.
- func values above 4 under ALUOp=2'b10 are forwarded unchanged; the ALU returns 0 (zeroOut=1, errOut=0).
- Arithmetic and width: DATA_W-bit, modulo 2^DATA_W (multiply low half, shifts by full in2 value) — determined by the ALU; the arbiter adds no arithmetic.
- Only one of ack0/ack1 and one of done0/done1 is ever high; ack and done are never high in the same cycle.
- Fairness: under continuous requests from both sides, grants alternate 0,1,0,1…; neither waits more than one foreign operation.

Test Plan:
- Reset, then req0 with op0=00, a0=15, b0=24 -> ack0 in the next cycle; done0 one cycle later with result=39, zeroOut=0, errOut=0; busy high for 2 cycles.
- req1 with op1=01, a1=15, b1=15 -> done1, result=0, zeroOut=1; the prior result of 39 stays on result until the EXEC capture edge.
- Both requests in the same cycle after reset: req0 op=10/func=2, 15*3; req1 op=10/func=3, 15<<3.
  - Expected order: req0 first (result=45, done0), then req1 (result=120, done1).
  - Then both held high again -> grant order continues 0,1.
- req0 with op0=11, a0=7, b0=9 -> done0 with result=0, zeroOut=1, errOut=1.
  - A following legal op (op=10, func=4, 15>>3) clears errOut: result=1.
- Assert reset for half a cycle during EXEC of a granted op:
  - No done is issued; all outputs are 0 immediately (asynchronous).
  - The next req0 after release is served normally with ack/done timing unchanged.
- req1 held high continuously while req0 pulses once per 3 cycles:
  - ack0/ack1 alternate.
  - No double ack for a single req pulse.
  - ack and done never overlap.
